pp_accum_serial: RTL and testbench
==================================

PP_ACCUM_SERIAL -- requirements
Module: pp_accum_serial

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits.
REQ-002 SHALL have parameter TRUNC, default 0, number of low product columns discarded; legal range 0..2N-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a new product.
REQ-006 SHALL have port pp_valid  input  1  pp_bit is valid this cycle.
REQ-007 SHALL have port pp_bit  input  1  one partial-product bit a[i]&b[j], delivered in row-major order (i outer, j inner).
REQ-008 SHALL have port pp_ready  output  1  block accepts pp_bit this cycle.
REQ-009 SHALL have port res  output  2N  accumulated product.
REQ-010 SHALL have port res_valid  output  1  res holds a completed product.
REQ-011 SHALL have port res_ready  input  1  consumer takes res.
REQ-012 SHALL have port busy  output  1  high in ACCUM and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, DONE; all outputs registered or decoded from state only.
REQ-014 IDLE: pp_ready=0, res_valid=0, busy=0; start=1 -> ACCUM next cycle, with acc=0 and i=j=0.
REQ-015 ACCUM: pp_ready=1, busy=1; a transfer occurs when pp_valid&&pp_ready.
REQ-016 On a transfer, column c=i+j; if pp_bit=1 and c>=TRUNC, acc SHALL increase by 2^c; otherwise acc is unchanged.
REQ-017 After each transfer, j SHALL increment; j=N-1 wraps to 0 and increments i.
REQ-018 pp_valid=0 in ACCUM SHALL leave acc, i, j unchanged (stall, no timeout).
REQ-019 The transfer at i=j=N-1 SHALL move to DONE, with res loaded with the final acc (including that bit) on the same edge.
REQ-020 Latency: res_valid SHALL rise the cycle after the N*N-th transfer; minimum N*N+1 cycles after the start edge.
REQ-021 DONE: res_valid=1, pp_ready=0, busy=1; res SHALL remain stable until handshake.
REQ-022 res_valid&&res_ready SHALL return the FSM to IDLE; if start=1 in the same cycle, the FSM SHALL go directly to ACCUM with acc cleared (back-to-back operation).
REQ-023 start while in ACCUM, or while in DONE without the handshake, SHALL be ignored.
REQ-024 acc and res SHALL be 2N bits wide; maximum sum (2^N-1)^2 SHALL never overflow.
REQ-025 res SHALL retain its last value in IDLE.
REQ-026 TRUNC=0 SHALL give the exact product; TRUNC=2N-1 SHALL give res=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, acc=0, i=j=0, res=0, res_valid=0, pp_ready=0, busy=0, independent of clk.
REQ-028 Reset asserted mid-ACCUM or in DONE SHALL discard the partial or pending result; the first start after release SHALL behave as REQ-014.

Verification (N=8)
REQ-029 TRUNC=0, a=0xFF, b=0xFF, 64 back-to-back transfers -> res=0xFE01, res_valid rises 1 cycle after the last transfer.
REQ-030 TRUNC=4, a=0x0F, b=0x0F -> res=0x00B0 (exact result 0x00E1 with TRUNC=0).
REQ-031 TRUNC=0, a=0x03, b=0x05 with random pp_valid gaps -> res=0x000F; acc, i, j frozen during gaps.
REQ-032 res_ready held 0 for 10 cycles in DONE -> res_valid=1, res stable, pp_ready=0; handshake with start=1 -> ACCUM next cycle, pp_ready=1, next product correct.
REQ-033 rst_n pulsed low after 30 transfers -> all outputs 0 asynchronously, state IDLE; next product a=0x12, b=0x34 -> res=0x03A8.
REQ-034 start pulsed at transfer 10 during ACCUM -> ignored; product completes unchanged.

Source files
------------

// File: rtl/pp_accum_serial.sv
// Bit-serial partial-product accumulator: sums a[i]&b[j] bits (row-major) into a
// 2N-bit product, dropping columns below TRUNC, with a valid/ready result port.
module pp_accum_serial #(
  parameter int unsigned N     = 8,
  parameter int unsigned TRUNC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            pp_valid,
  input  logic            pp_bit,
  output logic            pp_ready,
  output logic [2*N-1:0]  res,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy
);

  localparam int unsigned AW      = 2 * N;
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int          TRUNC_I = int'(TRUNC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, acc_n;
  logic [AW-1:0]   res_q, res_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            pp_ready_q, pp_ready_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic            xfer;
  logic            last_i, last_j;
  int              col;

  assign pp_ready  = pp_ready_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_n   = acc_q;
    col     = 32'(i_q) + 32'(j_q);
    last_i  = (i_q == IW'(N - 1));
    last_j  = (j_q == IW'(N - 1));
    xfer    = pp_valid && pp_ready_q;

    if (pp_bit && (col >= TRUNC_I)) begin
      acc_n = acc_q + (AW'(1) << col);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_d = acc_n;
          if (last_j) begin
            j_d = '0;
            if (last_i) begin
              state_d = S_DONE;
              res_d   = acc_n;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        // Handshake with a coincident start restarts immediately
        if (res_ready) begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pp_ready_d  = (state_d == S_ACCUM);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_ACCUM) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      res_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      pp_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      i_q         <= i_d;
      j_q         <= j_d;
      pp_ready_q  <= pp_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pp_accum_serial.sv
// Randomized self-checking bench for pp_accum_serial (N=8) with TRUNC = 0, 4, 15
// instances sharing one stimulus stream, checked against an arithmetic model.
module tb_pp_accum_serial;

  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, pp_valid, pp_bit, res_ready;
  logic          pp_ready, res_valid, busy;
  logic          pp_ready4, res_valid4, busy4;
  logic          pp_ready15, res_valid15, busy15;
  logic [15:0]   res0, res4, res15;

  int n_vec = 0;
  int n_err = 0;
  bit in_accum = 0;

  always #5 clk = ~clk;

  pp_accum_serial #(.N(N), .TRUNC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pp_valid(pp_valid), .pp_bit(pp_bit),
    .pp_ready(pp_ready), .res(res0), .res_valid(res_valid), .res_ready(res_ready), .busy(busy));
  pp_accum_serial #(.N(N), .TRUNC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pp_valid(pp_valid), .pp_bit(pp_bit),
    .pp_ready(pp_ready4), .res(res4), .res_valid(res_valid4), .res_ready(res_ready), .busy(busy4));
  pp_accum_serial #(.N(N), .TRUNC(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .start(start), .pp_valid(pp_valid), .pp_bit(pp_bit),
    .pp_ready(pp_ready15), .res(res15), .res_valid(res_valid15), .res_ready(res_ready), .busy(busy15));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truncated product: full product minus every a[i]*b[j]*2^(i+j) term with i+j < t
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int t);
    logic [31:0] full, low, mask;
    full = 32'(a) * 32'(b);
    low  = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i] && (t > i)) begin
        mask = (32'd1 << (t - i)) - 32'd1;
        low  = low + ((32'(b) & mask) << i);
      end
    end
    return 16'(full - low);
  endfunction

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_res0"}, 32'(res0), 32'd0);
    chk({tag, "_res4"}, 32'(res4), 32'd0);
    chk({tag, "_res15"}, 32'(res15), 32'd0);
    chk({tag, "_flags"}, {29'd0, pp_ready, res_valid, busy}, 32'd0);
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("launch_flags", {29'd0, pp_ready, res_valid, busy}, 32'b101);
  endtask

  // Streams transfers from ACCUM; stops before transfer abort_at if it is >= 0
  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int gap_pct,
                      input int glitch_at, input int abort_at);
    for (int k = 0; k < N * N; k++) begin
      if (k == abort_at) begin
        pp_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      for (int g = 0; g < 3 && int'($urandom_range(99, 0)) < gap_pct; g++) begin
        pp_valid = 1'b0;
        pp_bit   = 1'($urandom);
        start    = 1'b0;
        @(negedge clk);
      end
      pp_valid = 1'b1;
      pp_bit   = a[k / N] & b[k % N];
      start    = (k == glitch_at);
      if (k == N * N - 1) chk("pre_last_valid", {30'd0, pp_ready, res_valid}, 32'b10);
      @(negedge clk);
    end
    pp_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic collect(input logic [7:0] a, input logic [7:0] b, input int hold, input bit b2b);
    logic [15:0] e0, e4, e15;
    e0  = model(a, b, 0);
    e4  = model(a, b, 4);
    e15 = model(a, b, 15);
    chk("done_flags", {29'd0, pp_ready, res_valid, busy}, 32'b011);
    chk("res_t0", 32'(res0), 32'(e0));
    chk("res_t4", 32'(res4), 32'(e4));
    chk("res_t15", 32'(res15), 32'(e15));
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start     = 1'($urandom);
      @(negedge clk);
      chk("hold_flags", {29'd0, pp_ready, res_valid, busy}, 32'b011);
      chk("hold_res", 32'(res0), 32'(e0));
    end
    res_ready = 1'b1;
    start     = b2b;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    chk("post_hs_flags", {29'd0, pp_ready, res_valid, busy}, {29'd0, b2b, 1'b0, b2b});
    chk("post_hs_res", 32'(res0), 32'(e0));
    in_accum = b2b;
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input int gap_pct,
                     input int glitch_at, input int hold, input bit b2b);
    if (!in_accum) launch();
    feed(a, b, gap_pct, glitch_at, -1);
    collect(a, b, hold, b2b);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pp_valid  = 1'b0;
    pp_bit    = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs_zero("idle");

    run(8'hFF, 8'hFF, 0, -1, 0, 1'b0);
    run(8'h0F, 8'h0F, 0, -1, 0, 1'b0);
    run(8'h03, 8'h05, 40, -1, 0, 1'b0);
    run(8'($urandom), 8'($urandom), 20, -1, 10, 1'b1);
    run(8'($urandom), 8'($urandom), 0, -1, 0, 1'b0);
    run(8'hA5, 8'h3C, 10, 10, 2, 1'b0);

    // Asynchronous reset mid-accumulation, away from any clock edge
    launch();
    feed(8'hFF, 8'hFF, 0, -1, 30);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs_zero("post_rst");
    run(8'h12, 8'h34, 0, -1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(8'($urandom), 8'($urandom), int'($urandom_range(50, 0)),
          (r % 3 == 0) ? int'($urandom_range(62, 1)) : -1,
          int'($urandom_range(3, 0)), 1'($urandom));
    end
    if (in_accum) begin
      run(8'($urandom), 8'($urandom), 0, -1, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
